// File: rtl/flag_status_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : flag_status_unit                                                  |
// | Brief  : NZCV status register, in-flight flag commit pipe, bypass or stall |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module flag_status_unit #(
  parameter int FLAG_LAT = 2,
  parameter bit BYPASS   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_freeze,
  input  logic       i_flush,
  input  logic       i_exe_valid,
  input  logic       i_exe_s,
  input  logic [3:0] i_exe_flags,
  input  logic       i_id_valid,
  input  logic       i_id_needs_flags,
  output logic [3:0] o_status_out,
  output logic       o_flag_stall,
  output logic [2:0] o_pending_cnt
);

  localparam logic [2:0] c_CNT_MAX  = 3'd4;
  localparam bit         c_STALL_EN = (BYPASS == 1'b0);

  logic [FLAG_LAT-1:0] r_pipe_vld;
  logic [3:0]          r_pipe_flags [FLAG_LAT];
  logic [3:0]          r_status;

  logic       w_exe_set;
  logic       w_any_pend;
  logic       w_young_vld;
  logic [3:0] w_young_flags;
  logic [3:0] w_fwd_flags;
  logic [2:0] w_cnt;
  logic       w_stall_req;

  assign w_exe_set = i_exe_valid & i_exe_s & ~i_flush;

  // Flags enter at pipe[0]; the last stage commits whole nibbles only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < FLAG_LAT; k++) begin
        r_pipe_flags[k] <= 4'b0000;
      end
      r_status <= 4'b0000;
    end else if (!i_freeze) begin
      r_pipe_vld[0]   <= w_exe_set;
      r_pipe_flags[0] <= i_exe_flags;
      for (int k = 1; k < FLAG_LAT; k++) begin
        r_pipe_vld[k]   <= r_pipe_vld[k-1];
        r_pipe_flags[k] <= r_pipe_flags[k-1];
      end
      if (r_pipe_vld[FLAG_LAT-1]) begin
        r_status <= r_pipe_flags[FLAG_LAT-1];
      end
    end
  end

  // Scan oldest to youngest so the lowest-index valid entry wins.
  always_comb begin
    w_young_vld   = 1'b0;
    w_young_flags = 4'b0000;
    w_cnt         = 3'd0;
    for (int k = FLAG_LAT - 1; k >= 0; k--) begin
      if (r_pipe_vld[k]) begin
        w_young_vld   = 1'b1;
        w_young_flags = r_pipe_flags[k];
      end
      w_cnt = w_cnt + {2'b00, r_pipe_vld[k]};
    end
  end

  assign w_any_pend  = |r_pipe_vld;
  assign w_fwd_flags = w_exe_set   ? i_exe_flags   :
                       w_young_vld ? w_young_flags : r_status;
  assign w_stall_req = i_id_valid & i_id_needs_flags & (w_exe_set | w_any_pend);

  assign o_status_out  = BYPASS ? w_fwd_flags : r_status;
  assign o_flag_stall  = c_STALL_EN & w_stall_req;
  assign o_pending_cnt = (w_cnt > c_CNT_MAX) ? c_CNT_MAX : w_cnt;

endmodule
`default_nettype wire
